// File: rtl/shift_in_register.sv
// Serial-to-parallel JTAG receive path: MSB-first shift into a LENGTH-bit word, double-buffered
// into a valid/ready holding register. Optional even-parity frame bit via SHIFT_IN_PARITY_EN.
module shift_in_register #(
   parameter int unsigned LENGTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jtagInput,
   input  logic              shiftEn,
   input  logic              clear,
   output logic [LENGTH-1:0] socInput,
   output logic              socValid,
   input  logic              socReady,
   output logic              overrun,
   output logic              socError
);

`ifdef SHIFT_IN_PARITY_EN
   localparam int unsigned FRAME = LENGTH + 1;
`else
   localparam int unsigned FRAME = LENGTH;
`endif
   localparam int unsigned CW = $clog2(LENGTH + 2);
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic [LENGTH-1:0] shift_q;
   logic [LENGTH-1:0] shift_d;
   logic [LENGTH-1:0] word_d;
   logic              err_d;
   logic              complete_d;
   logic              load_d;

   always_comb begin
      shift_d    = (shift_q << 1) | LENGTH'(jtagInput);
      complete_d = shiftEn && !clear && (state_q == SHIFT) && (cnt_q == LAST);
`ifdef SHIFT_IN_PARITY_EN
      // Data is already complete in shift_q; the bit on this edge is parity only.
      word_d     = shift_q;
      err_d      = ^{shift_q, jtagInput};
`else
      word_d     = shift_d;
      err_d      = 1'b0;
`endif
      load_d     = complete_d && (!socValid || socReady);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         socInput <= '0;
         socValid <= 1'b0;
         overrun  <= 1'b0;
         socError <= 1'b0;
      end else begin
         if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            overrun <= 1'b0;
         end else if (shiftEn) begin
            shift_q <= shift_d;
            if (complete_d) begin
               state_q <= IDLE;
               cnt_q   <= '0;
               if (socValid && !socReady)
                  overrun <= 1'b1;
            end else begin
               state_q <= SHIFT;
               cnt_q   <= cnt_q + 1'b1;
            end
         end

         // Holding register: a completing word may replace one being accepted this cycle.
         if (load_d) begin
            socInput <= word_d;
            socError <= err_d;
            socValid <= 1'b1;
         end else if (socReady) begin
            socValid <= 1'b0;
         end
      end
   end

endmodule
